// File: rtl/regfile_wport_arbiter_if.sv
// Write-port bundle between the WB stage / long-latency unit (master) and the
// register-file write-port arbiter (slave).
interface regfile_wport_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int REG_NUM = 5
);
  logic                    a_we;
  logic [REG_NUM-1:0]      a_wa;
  logic [WIDTH-1:0]        a_wd;
  logic                    b_valid;
  logic [REG_NUM-1:0]      b_wa;
  logic [WIDTH-1:0]        b_wd;
  logic                    b_ready;
  logic                    iss_valid;
  logic [REG_NUM-1:0]      iss_wa;
  logic [2**REG_NUM-1:0]   busy;
  logic                    stall_req;
  logic                    regwrite;
  logic [REG_NUM-1:0]      wa;
  logic [WIDTH-1:0]        wd;

  modport master (
    output a_we, a_wa, a_wd, b_valid, b_wa, b_wd, iss_valid, iss_wa,
    input  b_ready, busy, stall_req, regwrite, wa, wd
  );

  modport slave (
    input  a_we, a_wa, a_wd, b_valid, b_wa, b_wd, iss_valid, iss_wa,
    output b_ready, busy, stall_req, regwrite, wa, wd
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Shares the regfile write port between WB (fixed priority) and the long-latency
// unit (valid/ready), with a pending-write scoreboard and a starvation guard.
module regfile_wport_arbiter #(
  parameter int WIDTH      = 32,
  parameter int REG_NUM    = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_wport_arbiter_if.slave  wp
);
  localparam int NREG = 2**REG_NUM;

  logic [3:0]       cnt_q, cnt_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic             a_req, stall, grant_a, grant_b;
  logic             regwrite_c;
  logic [REG_NUM-1:0] wa_c;
  logic [WIDTH-1:0]   wd_c;

  always_comb begin
    a_req   = wp.a_we && (wp.a_wa != '0);
    stall   = (cnt_q == 4'(STARVE_MAX));
    // rst_n gates the grants so the write port is quiet during reset.
    grant_b = rst_n && wp.b_valid && (stall || !a_req);
    grant_a = rst_n && a_req && !stall && !grant_b;

    regwrite_c = grant_a || (grant_b && (wp.b_wa != '0));
    wa_c       = '0;
    wd_c       = '0;
    if (grant_a) begin
      wa_c = wp.a_wa;
      wd_c = wp.a_wd;
    end else if (grant_b) begin
      wa_c = wp.b_wa;
      wd_c = wp.b_wd;
    end

    if (!wp.b_valid || grant_b)
      cnt_d = '0;
    else if (cnt_q < 4'(STARVE_MAX))
      cnt_d = cnt_q + 4'd1;
    else
      cnt_d = cnt_q;

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    busy_d = busy_q;
    if (grant_b)
      busy_d[wp.b_wa] = 1'b0;
    if (wp.iss_valid && (wp.iss_wa != '0))
      busy_d[wp.iss_wa] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign wp.b_ready   = grant_b;
  assign wp.stall_req = stall;
  assign wp.busy      = busy_q;
  assign wp.regwrite  = regwrite_c;
  assign wp.wa        = wa_c;
  assign wp.wd        = wd_c;
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: directed scenarios then random traffic,
// checked against a cycle-level reference model of the arbitration rules.
module tb_regfile_wport_arbiter;
  localparam int W  = 32;
  localparam int RN = 5;
  localparam int SM = 4;
  localparam int NR = 2**RN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  regfile_wport_arbiter_if #(.WIDTH(W), .REG_NUM(RN)) bus ();
  regfile_wport_arbiter #(.WIDTH(W), .REG_NUM(RN), .STARVE_MAX(SM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wp    (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: number of consecutive cycles B has waited, and pending set.
  int          m_wait;
  bit [NR-1:0] m_busy;
  bit          e_stall, e_ga, e_gb, e_rw;
  logic [RN-1:0] e_wa;
  logic [W-1:0]  e_wd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void predict();
    bit a_req;
    a_req   = bus.a_we && (bus.a_wa != 0);
    e_stall = (m_wait == SM);
    e_gb    = bus.b_valid && (e_stall || !a_req);
    e_ga    = !e_gb && !e_stall && a_req;
    e_rw    = e_ga || (e_gb && (bus.b_wa != 0));
    e_wa    = e_ga ? bus.a_wa : (e_gb ? bus.b_wa : '0);
    e_wd    = e_ga ? bus.a_wd : (e_gb ? bus.b_wd : '0);
  endfunction

  // Called mid-cycle: check outputs against the model, then advance one edge.
  task automatic cycle(input string tag);
    predict();
    chk({tag, "_stall"},    bus.stall_req, e_stall);
    chk({tag, "_b_ready"},  bus.b_ready,   e_gb);
    chk({tag, "_regwrite"}, bus.regwrite,  e_rw);
    chk({tag, "_busy"},     bus.busy,      m_busy);
    if (e_rw) begin
      chk({tag, "_wa"}, bus.wa, e_wa);
      chk({tag, "_wd"}, bus.wd, e_wd);
    end else if (!e_ga && !e_gb) begin
      chk({tag, "_idle_wa"}, bus.wa, 0);
      chk({tag, "_idle_wd"}, bus.wd, 0);
    end
    @(posedge clk);
    if (!bus.b_valid || e_gb) m_wait = 0;
    else if (m_wait < SM)     m_wait = m_wait + 1;
    if (e_gb) m_busy[bus.b_wa] = 1'b0;
    if (bus.iss_valid && bus.iss_wa != 0) m_busy[bus.iss_wa] = 1'b1;
    m_busy[0] = 1'b0;
    #1;
  endtask

  initial begin
    bit bpend;
    bus.a_we = 1'b1; bus.a_wa = 5'd3; bus.a_wd = 32'h1;
    bus.b_valid = 1'b1; bus.b_wa = 5'd6; bus.b_wd = 32'h2;
    bus.iss_valid = 1'b0; bus.iss_wa = '0;
    m_wait = 0; m_busy = '0;

    // Outputs quiet during reset even with both requesters active.
    #12;
    chk("rst_regwrite", bus.regwrite, 0);
    chk("rst_b_ready",  bus.b_ready,  0);
    chk("rst_stall",    bus.stall_req, 0);
    chk("rst_busy",     bus.busy, 0);
    @(posedge clk); #1;
    bus.b_valid = 1'b0;
    rst_n = 1'b1;

    // A alone writes through in the same cycle.
    bus.a_we = 1'b1; bus.a_wa = 5'd3; bus.a_wd = 32'h1234;
    #4;
    chk("t1_regwrite", bus.regwrite, 1);
    chk("t1_wa", bus.wa, 3);
    chk("t1_wd", bus.wd, 32'h1234);
    cycle("t1");

    // A to r0 leaves the port free for B.
    bus.a_wa = 5'd0; bus.b_valid = 1'b1; bus.b_wa = 5'd5; bus.b_wd = 32'hBEEF;
    #4;
    chk("t2_b_ready", bus.b_ready, 1);
    chk("t2_wa", bus.wa, 5);
    chk("t2_wd", bus.wd, 32'hBEEF);
    cycle("t2");

    // Starvation guard: B blocked STARVE_MAX cycles, then granted.
    bus.a_we = 1'b1; bus.a_wa = 5'd2; bus.a_wd = 32'hAAAA;
    bus.b_valid = 1'b1; bus.b_wa = 5'd7; bus.b_wd = 32'h7777;
    for (int i = 1; i <= SM; i++) begin
      #4;
      chk("t3_blocked_b_ready", bus.b_ready, 0);
      chk("t3_blocked_wa", bus.wa, 2);
      cycle("t3a");
    end
    #4;
    chk("t3_forced_stall", bus.stall_req, 1);
    chk("t3_forced_b_ready", bus.b_ready, 1);
    chk("t3_forced_wa", bus.wa, 7);
    cycle("t3b");
    bus.b_valid = 1'b0;
    #4;
    chk("t3_after_stall", bus.stall_req, 0);
    chk("t3_after_wa", bus.wa, 2);
    cycle("t3c");

    // Scoreboard set on issue, cleared on B grant.
    bus.a_we = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_wa = 5'd9;
    #4; cycle("t4a");
    bus.iss_valid = 1'b0;
    #4;
    chk("t4_busy9_set", bus.busy[9], 1);
    cycle("t4b");
    bus.b_valid = 1'b1; bus.b_wa = 5'd9; bus.b_wd = 32'h99;
    #4; cycle("t4c");
    bus.b_valid = 1'b0;
    #4;
    chk("t4_busy9_clr", bus.busy[9], 0);
    cycle("t4d");

    // Same-cycle clear and reissue of r9: set wins.
    bus.iss_valid = 1'b1; bus.iss_wa = 5'd9;
    #4; cycle("t5a");
    bus.b_valid = 1'b1; bus.b_wa = 5'd9;
    #4;
    chk("t5_b_ready", bus.b_ready, 1);
    cycle("t5b");
    bus.b_valid = 1'b0; bus.iss_valid = 1'b0;
    #4;
    chk("t5_busy9_kept", bus.busy[9], 1);
    cycle("t5c");

    // B result to r0 is consumed without a regfile write.
    bus.b_valid = 1'b1; bus.b_wa = 5'd0; bus.b_wd = 32'h55;
    #4;
    chk("t5_r0_b_ready", bus.b_ready, 1);
    chk("t5_r0_regwrite", bus.regwrite, 0);
    cycle("t5d");
    bus.b_valid = 1'b0;

    // Reset mid-operation with busy[4] set and the wait counter at 3.
    bus.iss_valid = 1'b1; bus.iss_wa = 5'd4;
    #4; cycle("t6a");
    bus.iss_valid = 1'b0;
    bus.a_we = 1'b1; bus.a_wa = 5'd2; bus.b_valid = 1'b1; bus.b_wa = 5'd7;
    for (int i = 0; i < 3; i++) begin
      #4; cycle("t6b");
    end
    #4;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_stall", bus.stall_req, 0);
    chk("t6_rst_regwrite", bus.regwrite, 0);
    chk("t6_rst_b_ready", bus.b_ready, 0);
    m_wait = 0; m_busy = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 1; i <= SM; i++) begin
      #4;
      chk("t6_restart_stall", bus.stall_req, 0);
      cycle("t6c");
    end
    #4;
    chk("t6_restart_forced", bus.stall_req, 1);
    cycle("t6d");
    bus.b_valid = 1'b0;

    // Random traffic; B holds its payload until accepted, A holds while stalled.
    bpend = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (m_wait != SM) begin
        bus.a_we = ($urandom_range(0, 3) != 0);
        bus.a_wa = RN'($urandom);
        bus.a_wd = $urandom;
      end
      if (!bpend && $urandom_range(0, 2) == 0) begin
        bpend = 1'b1;
        bus.b_wa = RN'($urandom);
        bus.b_wd = $urandom;
      end
      bus.b_valid = bpend;
      bus.iss_valid = ($urandom_range(0, 3) == 0);
      bus.iss_wa = RN'($urandom);
      #4;
      cycle("rnd");
      if (e_gb) bpend = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the register file's single write port (regwrite/wa/wd) between two writers:
  - the pipeline writeback stage (port A, fixed priority, no handshake);
  - the multi-cycle mul/div/load-miss unit (port B, valid/ready).
- Keeps a per-register pending-write scoreboard for long-latency results; the hazard unit uses it for stall decisions.
- Starvation guard: forces a pipeline writeback stall so B always drains.
- Sits between the WB stage, the long-latency unit and regfile.

Parameters:
- WIDTH, 32, data width of a register.
- REG_NUM, 5, register address width; scoreboard has 2**REG_NUM entries.
- STARVE_MAX, 4, cycles B may wait while valid before A is forced to yield; range 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_we  in  1  WB stage write request.
- a_wa  in  REG_NUM  WB destination register.
- a_wd  in  WIDTH  WB write data.
- b_valid  in  1  long-latency result valid; must hold b_wa/b_wd stable until b_ready.
- b_wa  in  REG_NUM  long-latency destination register.
- b_wd  in  WIDTH  long-latency result data.
- b_ready  out  1  B result consumed this cycle.
- iss_valid  in  1  long-latency op issued this cycle.
- iss_wa  in  REG_NUM  destination of issued op.
- busy  out  2**REG_NUM  scoreboard, bit r = write to r pending from B.
- stall_req  out  1  A not accepted this cycle; WB stage must hold and retry.
- regwrite  out  1  to regfile write enable.
- wa  out  REG_NUM  to regfile write address.
- wd  out  WIDTH  to regfile write data.

Behaviour:
- Reset (rst_n low, async): busy=0, starve counter cnt=0. While rst_n is low, regwrite=0, b_ready=0 and stall_req=0, regardless of inputs.
- Effective requests:
  - a_req = a_we && a_wa!=0.
  - A write to r0 is a no-op; the port is treated as free.
- Registered state: cnt (4 bit, saturating at STARVE_MAX) and busy.
  - stall_req = (cnt == STARVE_MAX). Decoded from the register, so no combinational path from inputs.
- Grant, combinational within the cycle:
  - If stall_req && b_valid: B granted; A blocked.
  - Else if a_req: A granted; b_ready=0.
  - Else if b_valid: B granted.
  - Else: idle.
- A with a_we=1 is consumed iff stall_req=0. While stall_req=1, WB must hold a_* unchanged.
- B granted: b_ready=1.
  - regwrite=1, wa=b_wa, wd=b_wd, unless b_wa==0. In that case the result is consumed with regwrite=0.
- A granted: regwrite=1, wa=a_wa, wd=a_wd.
- Idle: regwrite=0. wa and wd are driven to 0.
- Zero latency: the regfile captures the write on the same rising edge the grant is made.
- cnt update:
  - Cleared to 0 when b_valid=0 or b_ready=1.
  - Otherwise incremented, saturating at STARVE_MAX.
  - Consequence: after STARVE_MAX consecutive blocked cycles, the next cycle grants B.
- busy update on each rising edge:
  - Set: iss_valid && iss_wa!=0 sets busy[iss_wa].
  - Clear: a B grant clears busy[b_wa].
  - Same register set and cleared in one cycle: set wins (back-to-back reuse).
  - Issue to a register already busy: bit stays 1. Preventing this is the hazard unit's job.
  - busy[0] is constantly 0.
- An A write to a busy register is permitted and leaves busy unchanged.
- Reset mid-operation: pending busy bits and cnt are lost. The long-latency unit is reset by the same rst_n.

Test Plan:
- Reset, then a_we=1, a_wa=3, a_wd=32'h1234 with b_valid=0 -> regwrite=1, wa=3, wd=32'h1234 same cycle; stall_req=0.
- a_we=1, a_wa=0 with b_valid=1, b_wa=5, b_wd=32'hBEEF -> B granted: b_ready=1, regwrite=1, wa=5.
- STARVE_MAX=4; a_we=1 (a_wa=2) held continuously with b_valid=1 (b_wa=7) -> b_ready=0 for cycles 1-4. Cycle 5: stall_req=1, b_ready=1, wa=7. Cycle 6: stall_req=0 and A written (wa=2).
- iss_valid=1, iss_wa=9 -> busy[9]=1 next cycle. Later B result to r9 granted -> busy[9]=0 after that edge.
- Same cycle: B grant to r9 and iss_valid=1 with iss_wa=9 -> busy[9] remains 1.
- busy[4]=1 and cnt=3, then assert rst_n=0 mid-cycle -> busy=0, stall_req=0, regwrite=0 immediately. After release: cnt restarts from 0.
